// File: rtl/sram_wait_responder_if.sv
// SRAM-style memory port between a MIPS core (master) and a memory responder
// (slave). The err signal exists only when SRAM_RESP_ERR_EN is defined.
interface sram_wait_responder_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stall;
`ifdef SRAM_RESP_ERR_EN
  logic        err;
`endif

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata, stall
`ifdef SRAM_RESP_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata, stall
`ifdef SRAM_RESP_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/sram_wait_responder.sv
// SRAM-port responder: word-addressed memory behind an IDLE/WAIT/DONE
// handshake with LATENCY wait cycles per transaction.
// Optional feature macro: SRAM_RESP_ERR_EN adds an out-of-range err output,
// suppresses out-of-range writes and returns zero data for them.
// ADDR_W is expected to stay within 1..29 so the address slices are legal.
module sram_wait_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  sram_wait_responder_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        commit;
  logic        stall_int;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wen_q;
  logic [31:0] rdata_q;

  logic [ADDR_W-1:0] idx;
  logic [31:0]       merged;
  logic              oor;
  logic              mem_we;

  // Zero at time 0 for simulation; never cleared by rst.
  logic [31:0] mem [DEPTH] = '{default: '0};

  // State and countdown register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state, countdown and stall decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    stall_int  = 1'b0;
    case (state)
      S_IDLE: begin
        stall_int = bus.sram_en;
        if (bus.sram_en) begin
          state_next = S_WAIT;
          count_next = LAT_INIT;
        end
      end
      S_WAIT: begin
        stall_int = 1'b1;
        if (count > 4'd1) begin
          count_next = count - 4'd1;
        end else begin
          commit     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= '0;
    end else if (state == S_IDLE && bus.sram_en) begin
      addr_q  <= bus.sram_addr;
      wdata_q <= bus.sram_wdata;
      wen_q   <= bus.sram_wen;
    end
  end

  assign idx = addr_q[ADDR_W+1:2];

`ifdef SRAM_RESP_ERR_EN
  assign oor = |addr_q[31:ADDR_W+2];
  logic addr_unused;
  assign addr_unused = ^addr_q[1:0];
`else
  assign oor = 1'b0;
  logic addr_unused;
  assign addr_unused = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};
`endif

  // Post-write word: stored word with the enabled byte lanes replaced.
  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (wen_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign mem_we = commit && (wen_q != 4'b0000) && !oor;

  // Memory write port, active only on the commit edge.
  // NOTE: the array has no reset branch; memories are not cleared by rst,
  // and a reset branch would stop the array mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  // Read data register, loaded on every commit and held until the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (commit) begin
      rdata_q <= oor ? 32'h0 : merged;
    end
  end

  assign bus.sram_rdata = rdata_q;
  assign bus.stall      = rst && stall_int;
`ifdef SRAM_RESP_ERR_EN
  assign bus.err        = (state == S_DONE) && oor;
`endif

endmodule

// File: tb/tb_sram_wait_responder.sv
// Directed bench for sram_wait_responder (ADDR_W=10, LATENCY=2). The driver
// pushes expected responses into a scoreboard; a monitor pops and compares
// them in each DONE cycle (first stall=0 cycle after a stall run).
module tb_sram_wait_responder;

  localparam int STALL_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_wait_responder_if bus();

  sram_wait_responder #(
    .ADDR_W (10),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: counts stall runs and checks the response in each DONE cycle.
  int run       = 0;
  int gap       = 0;
  int start_gap = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run = 0;
      gap = 0;
    end else if (bus.stall) begin
      if (run == 0) start_gap = gap;
      run++;
`ifdef SRAM_RESP_ERR_EN
      check("err_low_while_stalled", 32'(bus.err), 32'h0);
`endif
    end else begin
      if (run > 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_response: got rdata %h with empty scoreboard",
                   bus.sram_rdata);
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, bus.sram_rdata, e.rdata);
          check({e.name, "_stall_cycles"}, 32'(run), 32'(STALL_CYCLES));
          if (e.gap >= 0) check({e.name, "_done_gap"}, 32'(start_gap), 32'(e.gap));
`ifdef SRAM_RESP_ERR_EN
          check({e.name, "_err"}, 32'(bus.err), 32'(e.err));
`endif
        end
        gap = 0;
      end
      gap++;
      run = 0;
    end
  end

  // One transaction: drive, push expectation, wait (bounded) for DONE.
  task automatic txn(input string name, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_gap, input bit keep_en, input bit disturb);
    exp_t e;
    bit   done = 1'b0;
    @(posedge clk);
    #1;
    bus.sram_en    = 1'b1;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.gap   = exp_gap;
    sb.push_back(e);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        done = 1'b1;
      end else if (disturb && i == 1) begin
        // In WAIT: drop en and scramble inputs; latched copy must win.
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = 32'h0000_0040;
        bus.sram_wdata = 32'hFFFF_FFFF;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: stall got 1 expected 0 within 40 cycles", name);
    end
    if (!keep_en) begin
      @(posedge clk);
      #1;
      bus.sram_en = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(bus.stall), 32'h0);
    check("reset_rdata", bus.sram_rdata, 32'h0);
`ifdef SRAM_RESP_ERR_EN
    check("reset_err", 32'(bus.err), 32'h0);
`endif
    // Stall must stay low during reset even with a request present.
    bus.sram_en = 1'b1;
    #1;
    check("reset_stall_with_en", 32'(bus.stall), 32'h0);
    bus.sram_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full-word write then read back.
    txn("wr_full", 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, -1, 1'b0, 1'b0);
    txn("rd_full", 4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, -1, 1'b0, 1'b0);

    // Single byte lane 1.
    txn("wr_byte1", 4'b0010, 32'h0000_0010, 32'h0000_AA00, 32'hDEAD_AAEF, 1'b0, -1, 1'b0, 1'b0);
    txn("rd_byte1", 4'b0000, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0, -1, 1'b0, 1'b0);

    // Back-to-back reads with en held: exactly one DONE cycle between runs.
    txn("b2b_first",  4'b0000, 32'h0000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, -1, 1'b1, 1'b0);
    txn("b2b_second", 4'b0000, 32'h0000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0,  1, 1'b0, 1'b0);

    // Reset during the first WAIT cycle discards the write.
    @(posedge clk);
    #1;
    bus.sram_en    = 1'b1;
    bus.sram_wen   = 4'b1111;
    bus.sram_addr  = 32'h0000_0020;
    bus.sram_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midwait_rst_stall", 32'(bus.stall), 32'h0);
    check("midwait_rst_rdata", bus.sram_rdata, 32'h0);
    bus.sram_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    txn("rd_after_rst", 4'b0000, 32'h0000_0020, 32'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0);

    // Inputs scrambled and en dropped during WAIT: latched request completes.
    txn("wr_disturb", 4'b1111, 32'h0000_0030, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, -1, 1'b0, 1'b1);
    txn("rd_disturb", 4'b0000, 32'h0000_0030, 32'h0, 32'hA5A5_A5A5, 1'b0, -1, 1'b0, 1'b0);
    txn("rd_untouched", 4'b0000, 32'h0000_0040, 32'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0);

    // Top word, outer byte lanes; low address bits ignored on read.
    txn("wr_top", 4'b1001, 32'h0000_0FFC, 32'hAABB_CCDD, 32'hAA00_00DD, 1'b0, -1, 1'b0, 1'b0);
    txn("rd_top", 4'b0000, 32'h0000_0FFF, 32'h0,         32'hAA00_00DD, 1'b0, -1, 1'b0, 1'b0);

`ifdef SRAM_RESP_ERR_EN
    // Out of range: err in DONE only, zero data, write suppressed.
    txn("wr_oor", 4'b1111, 32'h0000_1010, 32'h1111_1111, 32'h0, 1'b1, -1, 1'b0, 1'b0);
    txn("rd_after_oor", 4'b0000, 32'h0000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, -1, 1'b0, 1'b0);
`else
    // Upper address bits truncated: 0x1010 aliases 0x10.
    txn("wr_alias", 4'b1111, 32'h0000_1010, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, -1, 1'b0, 1'b0);
    txn("rd_alias", 4'b0000, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0, -1, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
